// File: rtl/pipeline_stall_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_sequencer_pkg
// Description : Shared state encoding and default parameter values for the
//               5-stage pipeline stall/flush sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_stall_sequencer_pkg;

  // Sequencer states; the encoding is fixed so it can be observed in debug.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_HOLD = 2'd1,
    MC_WAIT = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_MC_TIMEOUT   = 64;

  // Counter widths sized for the largest legal FLUSH_CYCLES / MC_TIMEOUT.
  localparam int FLUSH_CNT_W = 4;
  localparam int WAIT_CNT_W  = 10;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with enable that sticks at all-ones instead of
//               wrapping; asynchronous active-low clear.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_sequencer
// Description : Mealy stall / bubble / flush sequencer for the 5-stage MIPS
//               pipeline: branch flush, load-use stall, multi-cycle unit wait
//               with timeout, and a saturating stall-cycle counter.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_stall_sequencer
  import pipeline_stall_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MC_TIMEOUT   = DEF_MC_TIMEOUT,
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadUse_Req,
  input  logic             Branch_Taken,
  input  logic             MC_Start,
  input  logic             MC_Done,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MC_Busy,
  output logic             MC_Error,
  output logic [CNT_W-1:0] StallCount
);

  state_t                 state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic                   err_set;
  logic                   pc_we, ifid_we, ifid_fl, idex_bub, busy;

  // State, flush/wait counters and the sticky timeout flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      MC_Error  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (err_set) begin
        MC_Error <= 1'b1;
      end
    end
  end

  // Next-state and Mealy outputs; branch beats load-use beats MC_Start.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    err_set       = 1'b0;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_fl       = 1'b0;
    idex_bub      = 1'b0;
    busy          = 1'b0;
    case (state)
      RUN, LU_HOLD: begin
        if (Branch_Taken) begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt = RUN;
          end
        end else if (LoadUse_Req && (state == RUN)) begin
          // The producer moves to MEM next cycle, so LU_HOLD masks the request.
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_bub  = 1'b1;
          state_nxt = LU_HOLD;
        end else if (MC_Start) begin
          // Issue cycle advances normally; the stall starts in MC_WAIT.
          state_nxt    = MC_WAIT;
          wait_cnt_nxt = '0;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        ifid_fl       = 1'b1;
        idex_bub      = 1'b1;
        flush_cnt_nxt = flush_cnt - 1'b1;
        if (flush_cnt <= FLUSH_CNT_W'(1)) begin
          state_nxt = RUN;
        end
      end
      MC_WAIT: begin
        busy = 1'b1;
        if (MC_Done) begin
          state_nxt = RUN;
        end else begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_bub = 1'b1;
          if (wait_cnt == WAIT_CNT_W'(MC_TIMEOUT - 1)) begin
            err_set   = 1'b1;
            state_nxt = RUN;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // All control outputs read 0 while reset is held.
  assign PC_Write    = Reset & pc_we;
  assign IFID_Write  = Reset & ifid_we;
  assign IFID_Flush  = Reset & ifid_fl;
  assign IDEX_Bubble = Reset & idex_bub;
  assign MC_Busy     = Reset & busy;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (Clk),
    .clr_n (Reset),
    .en    (~pc_we),
    .count (StallCount)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_sequencer
// Description : Table-driven bench for pipeline_stall_sequencer plus
//               hand-written reset-during-wait and single-cycle-flush checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        LoadUse_Req = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic        MC_Start = 1'b0;
  logic        MC_Done = 1'b0;

  logic        a_pc, a_ifw, a_fl, a_bub, a_busy, a_err;
  logic [3:0]  a_cnt;
  logic        b_pc, b_ifw, b_fl, b_bub, b_busy, b_err;
  logic [31:0] b_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  // Main instance: 3-cycle flush, short timeout, narrow counter.
  pipeline_stall_sequencer #(
    .FLUSH_CYCLES (3),
    .MC_TIMEOUT   (8),
    .CNT_W        (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .LoadUse_Req  (LoadUse_Req),
    .Branch_Taken (Branch_Taken),
    .MC_Start     (MC_Start),
    .MC_Done      (MC_Done),
    .PC_Write     (a_pc),
    .IFID_Write   (a_ifw),
    .IFID_Flush   (a_fl),
    .IDEX_Bubble  (a_bub),
    .MC_Busy      (a_busy),
    .MC_Error     (a_err),
    .StallCount   (a_cnt)
  );

  // Second instance: single-cycle flush, long timeout (reaches wait count 10).
  pipeline_stall_sequencer #(
    .FLUSH_CYCLES (1),
    .MC_TIMEOUT   (16),
    .CNT_W        (32)
  ) dut_b (
    .Clk          (Clk),
    .Reset        (Reset),
    .LoadUse_Req  (LoadUse_Req),
    .Branch_Taken (Branch_Taken),
    .MC_Start     (MC_Start),
    .MC_Done      (MC_Done),
    .PC_Write     (b_pc),
    .IFID_Write   (b_ifw),
    .IFID_Flush   (b_fl),
    .IDEX_Bubble  (b_bub),
    .MC_Busy      (b_busy),
    .MC_Error     (b_err),
    .StallCount   (b_cnt)
  );

  // in   = {Reset, LoadUse_Req, Branch_Taken, MC_Start, MC_Done}
  // outs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, MC_Busy, MC_Error}
  typedef struct {
    logic [4:0] in;
    logic [5:0] outs;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] in, input logic [5:0] outs, input int cnt);
    vec_t v;
    v.in   = in;
    v.outs = outs;
    v.cnt  = 4'(cnt);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] act;
    logic [9:0] exp;

    // Reset, then idle RUN
    add(5'b00000, 6'b000000, 0);
    add(5'b10000, 6'b110000, 0);
    // LoadUse_Req held 2 cycles: stall then masked in LU_HOLD
    add(5'b11000, 6'b000100, 0);
    add(5'b11000, 6'b110000, 1);
    add(5'b10000, 6'b110000, 1);
    // Branch, 3 flush cycles, LoadUse_Req in flush cycle 2 ignored
    add(5'b10100, 6'b111100, 1);
    add(5'b11000, 6'b111100, 1);
    add(5'b10000, 6'b111100, 1);
    add(5'b10000, 6'b110000, 1);
    // MC_Done outside MC_WAIT ignored
    add(5'b10001, 6'b110000, 1);
    // MC_Start, 5 wait cycles (violating requests in one), then MC_Done
    add(5'b10010, 6'b110000, 1);
    add(5'b10000, 6'b000110, 1);
    add(5'b11110, 6'b000110, 2);
    add(5'b10000, 6'b000110, 3);
    add(5'b10000, 6'b000110, 4);
    add(5'b10000, 6'b000110, 5);
    add(5'b10001, 6'b110010, 6);
    add(5'b10000, 6'b110000, 6);
    // Load-use with branch: flush only, no stall counted
    add(5'b11100, 6'b111100, 6);
    add(5'b10000, 6'b111100, 6);
    add(5'b10000, 6'b111100, 6);
    add(5'b10000, 6'b110000, 6);
    // MC_Start honoured in LU_HOLD, Done on first wait cycle
    add(5'b11000, 6'b000100, 6);
    add(5'b11010, 6'b110000, 7);
    add(5'b10001, 6'b110010, 7);
    add(5'b10000, 6'b110000, 7);
    // Branch taken while in LU_HOLD
    add(5'b11000, 6'b000100, 7);
    add(5'b10100, 6'b111100, 8);
    add(5'b10000, 6'b111100, 8);
    add(5'b10000, 6'b111100, 8);
    add(5'b10000, 6'b110000, 8);
    // Timeout after 8 wait cycles; StallCount saturates at 15
    add(5'b10010, 6'b110000, 8);
    for (int k = 0; k < 8; k++) begin
      add(5'b10000, 6'b000110, 8 + k);
    end
    add(5'b10000, 6'b110001, 15);
    // Error is sticky; next MC_Start works normally
    add(5'b10010, 6'b110001, 15);
    add(5'b10000, 6'b000111, 15);
    add(5'b10001, 6'b110011, 15);
    add(5'b10000, 6'b110001, 15);
    add(5'b11000, 6'b000101, 15);
    add(5'b10000, 6'b110001, 15);
    // Reset clears everything
    add(5'b00000, 6'b000000, 0);
    add(5'b10000, 6'b110000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      {Reset, LoadUse_Req, Branch_Taken, MC_Start, MC_Done} = vecs[i].in;
      #1;
      act = {a_pc, a_ifw, a_fl, a_bub, a_busy, a_err, a_cnt};
      exp = {vecs[i].outs, vecs[i].cnt};
      n_vec++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                 i, act[9:4], act[3:0], exp[9:4], exp[3:0]);
      end
    end

    // Reset asserted while dut_b is in MC_WAIT with its wait counter at 10
    @(negedge Clk);
    {Reset, LoadUse_Req, Branch_Taken, MC_Start, MC_Done} = 5'b10010;
    @(negedge Clk);
    MC_Start = 1'b0;
    repeat (10) @(negedge Clk);
    #1;
    check("b_wait_busy", {63'd0, b_busy}, 64'd1);
    check("b_wait_stall", {62'd0, b_pc, b_ifw}, 64'd0);
    check("a_timeout_err", {62'd0, a_busy, a_err}, 64'd1);
    Reset = 1'b0;
    #1;
    check("b_in_reset", {26'd0, b_pc, b_ifw, b_fl, b_bub, b_busy, b_err, b_cnt}, 64'd0);
    check("a_in_reset", {54'd0, a_pc, a_ifw, a_fl, a_bub, a_busy, a_err, a_cnt}, 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("b_after_reset", {26'd0, b_pc, b_ifw, b_fl, b_bub, b_busy, b_err, b_cnt},
          {26'd0, 6'b110000, 32'd0});
    check("a_after_reset", {54'd0, a_pc, a_ifw, a_fl, a_bub, a_busy, a_err, a_cnt},
          {54'd0, 6'b110000, 4'd0});
    @(negedge Clk);
    #1;
    check("b_run_idle", {62'd0, b_busy, b_pc}, 64'd1);

    // FLUSH_CYCLES=1: one flush cycle on dut_b, three on dut
    @(negedge Clk);
    Branch_Taken = 1'b1;
    #1;
    check("b_flush_c1", {60'd0, b_pc, b_ifw, b_fl, b_bub}, 64'hF);
    @(negedge Clk);
    Branch_Taken = 1'b0;
    #1;
    check("b_flush_c2", {60'd0, b_pc, b_ifw, b_fl, b_bub}, 64'hC);
    check("a_flush_c2", {60'd0, a_pc, a_ifw, a_fl, a_bub}, 64'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
